hazard_scoreboard: RTL

- Hazard controller paired with the ID/EX pipeline register. It reads the decoded ID-stage instruction and tracks in-flight destination registers in a 3-entry scoreboard covering EX, MEM and WB.
- It drives `stall` to PC and IF/ID, and `bubble` to the ID/EX flush input.
- With forwarding compiled in, it also emits forward selects that travel into EX alongside the instruction.

---
 rtl/hazard_scoreboard_pkg.sv | 36 +++
 rtl/hazard_scoreboard_if.sv | 28 ++
 rtl/hazard_scoreboard_sb_match.sv | 20 ++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
//   sb_entry_t   : one in-flight destination {v, lw, td}
//   FWD_*        : forward-select encodings for fwd_a / fwd_b
//   RS_* / RT_*  : source-register field positions in the instruction word
//   fwd_sel()    : forward select from EX/MEM matches
package hazard_scoreboard_pkg;

    // Width of the td field; the top-level REG_W must equal this.
    localparam int unsigned SB_TD_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;

    typedef struct packed {
        logic               v;
        logic               lw;
        logic [SB_TD_W-1:0] td;
    } sb_entry_t;

    // EX wins over MEM; a load in EX cannot forward (it stalls instead).
    function automatic logic [1:0] fwd_sel(logic m_ex, logic lw_ex, logic m_mem);
        if (m_ex && !lw_ex) begin
            return FWD_EXMEM;
        end else if (m_mem) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface.
//   master : decode side, drives the ID instruction and BJ, receives controls
//   slave  : hazard controller, drives stall / bubble / forward selects
interface hazard_scoreboard_if #(
    parameter int unsigned REG_W = 5
);
    logic [31:0]      id_instr;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_td;
    logic             id_WREG;
    logic             id_LW;
    logic             BJ;
    logic             stall;
    logic             bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    modport master (
        output id_instr, id_use_rs, id_use_rt, id_td, id_WREG, id_LW, BJ,
        input  stall, bubble, fwd_a, fwd_b
    );

    modport slave (
        input  id_instr, id_use_rs, id_use_rt, id_td, id_WREG, id_LW, BJ,
        output stall, bubble, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// sb_match: combinational comparator of one source register against one
// scoreboard entry.
//   entry_i    : scoreboard entry {v, lw, td}
//   r_i        : source register index
//   use_i      : the ID instruction actually reads r_i
//   match_o    : entry will write r_i
//   lw_match_o : match_o and the producer is a load
module sb_match
    import hazard_scoreboard_pkg::*;
(
    input  sb_entry_t          entry_i,
    input  logic [SB_TD_W-1:0] r_i,
    input  logic               use_i,
    output logic               match_o,
    output logic               lw_match_o
);
    // $0 is hard-wired zero, so it never carries a dependency.
    assign match_o    = use_i & (r_i != '0) & entry_i.v & (entry_i.td == r_i);
    assign lw_match_o = match_o & entry_i.lw;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/bubble controller beside the ID/EX register.
// Tracks destinations in flight in EX, MEM and WB and compares them against
// the sources of the instruction in ID.
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   hz (slave)   : ID instruction info in; stall, bubble, fwd_a, fwd_b out
//   stall_cnt    : saturating count of stall cycles
// Build option HAZARD_FORWARD_EN: only load-use stalls, and forward selects
// are produced; without it fwd_* stay 00 and every RAW dependency stalls.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_W            = 5,
    parameter bit          WB_WRITE_THROUGH = 1'b1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  hz,
    output logic [CNT_W-1:0]    stall_cnt
);
    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q, sb_ex_d;
    sb_entry_t stage [3];

    logic [SB_TD_W-1:0] rs, rt;
    logic [2:0]         m_rs, m_rt, lwm_rs, lwm_rt;
    logic               haz;
    logic [CNT_W-1:0]   stall_cnt_q;

    assign rs = hz.id_instr[RS_HI:RS_LO];
    assign rt = hz.id_instr[RT_HI:RT_LO];

    assign stage[0] = sb_ex_q;
    assign stage[1] = sb_mem_q;
    assign stage[2] = sb_wb_q;

    for (genvar g = 0; g < 3; g++) begin : gen_match
        sb_match u_match_rs (
            .entry_i    (stage[g]),
            .r_i        (rs),
            .use_i      (hz.id_use_rs),
            .match_o    (m_rs[g]),
            .lw_match_o (lwm_rs[g])
        );
        sb_match u_match_rt (
            .entry_i    (stage[g]),
            .r_i        (rt),
            .use_i      (hz.id_use_rt),
            .match_o    (m_rt[g]),
            .lw_match_o (lwm_rt[g])
        );
    end

`ifdef HAZARD_FORWARD_EN
    assign haz = lwm_rs[0] | lwm_rt[0];
`else
    assign haz = m_rs[0] | m_rt[0] | m_rs[1] | m_rt[1]
               | (!WB_WRITE_THROUGH & (m_rs[2] | m_rt[2]));
`endif

    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign hz.stall  = !hz.BJ & haz;
    assign hz.bubble = hz.BJ | haz;

    always_comb begin
        hz.fwd_a = FWD_RF;
        hz.fwd_b = FWD_RF;
`ifdef HAZARD_FORWARD_EN
        if (!hz.stall && !hz.bubble) begin
            hz.fwd_a = fwd_sel(m_rs[0], sb_ex_q.lw, m_rs[1]);
            hz.fwd_b = fwd_sel(m_rt[0], sb_ex_q.lw, m_rt[1]);
        end
`endif
    end

    always_comb begin
        sb_ex_d = '0;
        if (!hz.bubble) begin
            sb_ex_d.v  = hz.id_WREG & (hz.id_td != '0);
            sb_ex_d.lw = hz.id_LW;
            sb_ex_d.td = SB_TD_W'(hz.id_td);
        end
    end

    // The scoreboard advances every cycle; a stall is covered by the bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_ex_q     <= '0;
            sb_mem_q    <= '0;
            sb_wb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_wb_q  <= sb_mem_q;
            sb_mem_q <= sb_ex_q;
            sb_ex_q  <= sb_ex_d;
            if (hz.stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{hz.id_instr[31:26], hz.id_instr[15:0], m_rs[2], m_rt[2],
                           lwm_rs, lwm_rt, sb_wb_q.lw};
endmodule
